// File: rtl/if_stage_if.sv
// Instruction-memory bus between the fetch stage and a combinational IMEM.
// The fetch stage is the master that drives the address.
interface if_stage_if;
    logic [15:0] imem_addr;
    logic [15:0] imem_data;

    modport master (
        output imem_addr,
        input  imem_data
    );

    modport slave (
        input  imem_addr,
        output imem_data
    );
endinterface

// File: rtl/if_stage.sv
// Fetch stage: PC register, IF/ID register, HLT freeze, redirect flush.
// Optional load-use stall counter enabled by macro IF_STALL_CNT_EN.
module if_stage #(
    parameter logic [15:0] RESET_PC   = 16'h0000,
    parameter logic [15:0] NOP_INSTR  = 16'h0000,
    parameter logic [3:0]  HLT_OPCODE = 4'hF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pc_stall,
    input  logic        ifid_stall,
    input  logic        redirect_en,
    input  logic [15:0] redirect_pc,
    if_stage_if.master  imem,
    output logic [15:0] d_instr,
    output logic [15:0] d_pc_plus1,
    output logic        d_valid,
    output logic        halted,
    output logic [15:0] stall_cycles
);

    logic [15:0] pc_q, pc_d;
    logic [15:0] instr_q, instr_d;
    logic [15:0] pcp1_q, pcp1_d;
    logic        valid_q, valid_d;
    logic        halt_q, halt_d;
    logic        pc_stall_on;
    logic        ifid_stall_on;
    logic [15:0] pc_inc;
    logic        hlt_fetch;

    // Unknown or floating stall lines must never freeze the pipe.
    assign pc_stall_on   = (pc_stall === 1'b1);
    assign ifid_stall_on = (ifid_stall === 1'b1);
    assign pc_inc        = pc_q + 16'd1;
    assign hlt_fetch     = (imem.imem_data[15:12] == HLT_OPCODE);

    always_comb begin
        pc_d    = pc_q;
        instr_d = instr_q;
        pcp1_d  = pcp1_q;
        valid_d = valid_q;
        halt_d  = halt_q;
        if (redirect_en) begin
            pc_d    = redirect_pc;
            instr_d = NOP_INSTR;
            pcp1_d  = 16'h0000;
            valid_d = 1'b0;
            halt_d  = 1'b0;
        end else if (halt_q) begin
            instr_d = NOP_INSTR;
            pcp1_d  = 16'h0000;
            valid_d = 1'b0;
        end else begin
            if (!pc_stall_on) begin
                pc_d = pc_inc;
            end
            if (!ifid_stall_on) begin
                instr_d = imem.imem_data;
                pcp1_d  = pc_inc;
                valid_d = 1'b1;
                halt_d  = hlt_fetch;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q    <= RESET_PC;
            instr_q <= NOP_INSTR;
            pcp1_q  <= 16'h0000;
            valid_q <= 1'b0;
            halt_q  <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            instr_q <= instr_d;
            pcp1_q  <= pcp1_d;
            valid_q <= valid_d;
            halt_q  <= halt_d;
        end
    end

`ifdef IF_STALL_CNT_EN
    logic [15:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (pc_stall_on && !redirect_en && (cnt_q != 16'hFFFF)) begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= 16'h0000;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign stall_cycles = cnt_q;
`else
    assign stall_cycles = 16'h0000;
`endif

    assign imem.imem_addr = pc_q;
    assign d_instr        = instr_q;
    assign d_pc_plus1     = pcp1_q;
    assign d_valid        = valid_q;
    assign halted         = halt_q;

endmodule

// File: tb/tb_if_stage.sv
// Directed-vector bench for if_stage; IMEM returns 16'h1000+addr except
// at hlt_addr, where it returns an HLT word.
module tb_if_stage;

`ifdef IF_STALL_CNT_EN
    localparam bit CNT = 1'b1;
`else
    localparam bit CNT = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        pc_stall = 1'b0;
    logic        ifid_stall = 1'b0;
    logic        redirect_en = 1'b0;
    logic [15:0] redirect_pc = 16'h0000;
    logic [15:0] d_instr, d_pc_plus1, stall_cycles;
    logic        d_valid, halted;
    logic [15:0] hlt_addr = 16'h8000;

    int vectors = 0;
    int miscompares = 0;

    if_stage_if bus ();

    assign bus.imem_data = (bus.imem_addr == hlt_addr) ? 16'hF000
                                                        : 16'h1000 + bus.imem_addr;

    if_stage dut (
        .clk          (clk),
        .rst          (rst),
        .pc_stall     (pc_stall),
        .ifid_stall   (ifid_stall),
        .redirect_en  (redirect_en),
        .redirect_pc  (redirect_pc),
        .imem         (bus),
        .d_instr      (d_instr),
        .d_pc_plus1   (d_pc_plus1),
        .d_valid      (d_valid),
        .halted       (halted),
        .stall_cycles (stall_cycles)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        pc_stall = 1'b0;
        ifid_stall = 1'b0;
        redirect_en = 1'b0;
        step();
        rst = 1'b0;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic test_reset();
        hlt_addr = 16'h8000;
        rst = 1'b1;
        steps(2);
        vectors++;
        if ({bus.imem_addr, d_instr, d_pc_plus1, d_valid, halted} !==
            {16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0}) begin
            miscompares++;
            $display("FAIL reset addr=%h instr=%h pcp1=%h v=%b h=%b want 0000 0000 0000 0 0",
                     bus.imem_addr, d_instr, d_pc_plus1, d_valid, halted);
        end
        vectors++;
        if (stall_cycles !== 16'h0000) begin
            miscompares++;
            $display("FAIL reset_cnt got %h want 0000", stall_cycles);
        end
        rst = 1'b0;
    endtask

    task automatic test_free_run();
        logic [15:0] exp_i;
        do_reset();
        for (int k = 0; k < 3; k++) begin
            step();
            exp_i = 16'h1000 + 16'(k);
            vectors++;
            if ({d_instr, d_pc_plus1, d_valid, bus.imem_addr} !==
                {exp_i, 16'(k + 1), 1'b1, 16'(k + 1)}) begin
                miscompares++;
                $display("FAIL free_run[%0d] instr=%h pcp1=%h v=%b addr=%h want %h %h 1 %h",
                         k, d_instr, d_pc_plus1, d_valid, bus.imem_addr,
                         exp_i, 16'(k + 1), 16'(k + 1));
            end
        end
    endtask

    task automatic test_stall();
        do_reset();
        steps(5);
        pc_stall = 1'b1;
        ifid_stall = 1'b1;
        for (int k = 0; k < 2; k++) begin
            step();
            vectors++;
            if ({bus.imem_addr, d_instr, d_valid} !== {16'h0005, 16'h1004, 1'b1}) begin
                miscompares++;
                $display("FAIL stall_hold[%0d] addr=%h instr=%h v=%b want 0005 1004 1",
                         k, bus.imem_addr, d_instr, d_valid);
            end
        end
        pc_stall = 1'b0;
        ifid_stall = 1'b0;
        vectors++;
        if (stall_cycles !== (CNT ? 16'd2 : 16'd0)) begin
            miscompares++;
            $display("FAIL stall_cnt got %h want %h", stall_cycles, CNT ? 16'd2 : 16'd0);
        end
        step();
        vectors++;
        if ({bus.imem_addr, d_instr, d_pc_plus1} !== {16'h0006, 16'h1005, 16'h0006}) begin
            miscompares++;
            $display("FAIL stall_release addr=%h instr=%h pcp1=%h want 0006 1005 0006",
                     bus.imem_addr, d_instr, d_pc_plus1);
        end
    endtask

    task automatic test_split_stall();
        do_reset();
        steps(2);
        pc_stall = 1'b1;
        step();
        step();
        vectors++;
        if ({bus.imem_addr, d_instr, d_pc_plus1} !== {16'h0002, 16'h1002, 16'h0003}) begin
            miscompares++;
            $display("FAIL dup addr=%h instr=%h pcp1=%h want 0002 1002 0003",
                     bus.imem_addr, d_instr, d_pc_plus1);
        end
        pc_stall = 1'b0;
        ifid_stall = 1'b1;
        step();
        vectors++;
        if ({bus.imem_addr, d_instr, d_pc_plus1} !== {16'h0003, 16'h1002, 16'h0003}) begin
            miscompares++;
            $display("FAIL drop addr=%h instr=%h pcp1=%h want 0003 1002 0003",
                     bus.imem_addr, d_instr, d_pc_plus1);
        end
        ifid_stall = 1'b0;
        step();
        vectors++;
        if ({d_instr, stall_cycles} !== {16'h1003, CNT ? 16'd2 : 16'd0}) begin
            miscompares++;
            $display("FAIL split_after instr=%h cnt=%h want 1003 %h",
                     d_instr, stall_cycles, CNT ? 16'd2 : 16'd0);
        end
    endtask

    task automatic test_redirect();
        do_reset();
        steps(8);
        redirect_en = 1'b1;
        redirect_pc = 16'h0040;
        pc_stall = 1'b1;
        ifid_stall = 1'b1;
        step();
        redirect_en = 1'b0;
        pc_stall = 1'b0;
        ifid_stall = 1'b0;
        vectors++;
        if ({bus.imem_addr, d_instr, d_pc_plus1, d_valid, stall_cycles} !==
            {16'h0040, 16'h0000, 16'h0000, 1'b0, 16'h0000}) begin
            miscompares++;
            $display("FAIL redirect addr=%h instr=%h pcp1=%h v=%b cnt=%h want 0040 0000 0000 0 0000",
                     bus.imem_addr, d_instr, d_pc_plus1, d_valid, stall_cycles);
        end
        step();
        vectors++;
        if ({d_instr, d_valid, bus.imem_addr} !== {16'h1040, 1'b1, 16'h0041}) begin
            miscompares++;
            $display("FAIL redirect_next instr=%h v=%b addr=%h want 1040 1 0041",
                     d_instr, d_valid, bus.imem_addr);
        end
    endtask

    task automatic test_halt();
        hlt_addr = 16'h0003;
        do_reset();
        steps(4);
        vectors++;
        if ({halted, d_instr, bus.imem_addr} !== {1'b1, 16'hF000, 16'h0004}) begin
            miscompares++;
            $display("FAIL halt_rise h=%b instr=%h addr=%h want 1 f000 0004",
                     halted, d_instr, bus.imem_addr);
        end
        steps(2);
        vectors++;
        if ({halted, d_valid, d_instr, bus.imem_addr} !== {1'b1, 1'b0, 16'h0000, 16'h0004}) begin
            miscompares++;
            $display("FAIL halt_hold h=%b v=%b instr=%h addr=%h want 1 0 0000 0004",
                     halted, d_valid, d_instr, bus.imem_addr);
        end
        redirect_en = 1'b1;
        redirect_pc = 16'h0010;
        step();
        redirect_en = 1'b0;
        vectors++;
        if ({halted, d_valid, bus.imem_addr} !== {1'b0, 1'b0, 16'h0010}) begin
            miscompares++;
            $display("FAIL halt_exit h=%b v=%b addr=%h want 0 0 0010",
                     halted, d_valid, bus.imem_addr);
        end
        step();
        vectors++;
        if ({d_instr, d_valid} !== {16'h1010, 1'b1}) begin
            miscompares++;
            $display("FAIL halt_resume instr=%h v=%b want 1010 1", d_instr, d_valid);
        end
    endtask

    task automatic test_hlt_flush();
        hlt_addr = 16'h0005;
        do_reset();
        steps(5);
        redirect_en = 1'b1;
        redirect_pc = 16'h0020;
        step();
        redirect_en = 1'b0;
        vectors++;
        if ({halted, d_valid, bus.imem_addr} !== {1'b0, 1'b0, 16'h0020}) begin
            miscompares++;
            $display("FAIL hlt_flush h=%b v=%b addr=%h want 0 0 0020",
                     halted, d_valid, bus.imem_addr);
        end
    endtask

    task automatic test_wrap();
        hlt_addr = 16'h8000;
        do_reset();
        redirect_en = 1'b1;
        redirect_pc = 16'hFFFE;
        step();
        redirect_en = 1'b0;
        steps(2);
        vectors++;
        if ({bus.imem_addr, d_instr, d_pc_plus1} !== {16'h0000, 16'h0FFF, 16'h0000}) begin
            miscompares++;
            $display("FAIL wrap addr=%h instr=%h pcp1=%h want 0000 0fff 0000",
                     bus.imem_addr, d_instr, d_pc_plus1);
        end
    endtask

    task automatic test_rst_in_halt();
        hlt_addr = 16'h0002;
        do_reset();
        steps(3);
        vectors++;
        if (halted !== 1'b1) begin
            miscompares++;
            $display("FAIL rst_halt_pre h=%b want 1", halted);
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        hlt_addr = 16'h8000;
        vectors++;
        if ({bus.imem_addr, halted, d_valid} !== {16'h0000, 1'b0, 1'b0}) begin
            miscompares++;
            $display("FAIL rst_halt addr=%h h=%b v=%b want 0000 0 0",
                     bus.imem_addr, halted, d_valid);
        end
        step();
        vectors++;
        if (d_instr !== 16'h1000) begin
            miscompares++;
            $display("FAIL rst_halt_fetch instr=%h want 1000", d_instr);
        end
    endtask

    task automatic test_x_stall();
        do_reset();
        steps(2);
        pc_stall = 1'bx;
        ifid_stall = 1'bz;
        step();
        vectors++;
        if ({bus.imem_addr, d_instr, stall_cycles} !== {16'h0003, 16'h1002, 16'h0000}) begin
            miscompares++;
            $display("FAIL x_stall addr=%h instr=%h cnt=%h want 0003 1002 0000",
                     bus.imem_addr, d_instr, stall_cycles);
        end
        pc_stall = 1'b0;
        ifid_stall = 1'b0;
    endtask

    initial begin
        test_reset();
        test_free_run();
        test_stall();
        test_split_stall();
        test_redirect();
        test_halt();
        test_hlt_flush();
        test_wrap();
        test_rst_in_halt();
        test_x_stall();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/if_stage.md
IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 16'h0000, meaning the PC value loaded on reset.
REQ-002 The block SHALL have parameter NOP_INSTR, default 16'h0000, meaning the bubble encoding written into IF/ID on flush.
REQ-003 The block SHALL have parameter HLT_OPCODE, default 4'hF, meaning the instr[15:12] value that halts fetch.
REQ-004 The block SHALL have the port: clk  in  1  single clock, all state on rising edge.
REQ-005 The block SHALL have the port: rst  in  1  synchronous, active-high reset.
REQ-006 The block SHALL have the port: pc_stall  in  1  hold PC (from hazard unit).
REQ-007 The block SHALL have the port: ifid_stall  in  1  hold IF/ID register (from hazard unit).
REQ-008 The block SHALL have the port: redirect_en  in  1  taken branch/jump/jr from EX.
REQ-009 The block SHALL have the port: redirect_pc  in  16  redirect target.
REQ-010 The block SHALL have the port: imem_addr  out  16  instruction memory address (= PC).
REQ-011 The block SHALL have the port: imem_data  in  16  combinational instruction memory read data.
REQ-012 The block SHALL have the port: d_instr  out  16  IF/ID instruction to decode.
REQ-013 The block SHALL have the port: d_pc_plus1  out  16  IF/ID PC+1 for jal/branch.
REQ-014 The block SHALL have the port: d_valid  out  1  IF/ID holds a real instruction.
REQ-015 The block SHALL have the port: halted  out  1  fetch frozen by HLT.
REQ-016 The block SHALL have the port: stall_cycles  out  16  load-use stall count (see Configuration).

Function
REQ-017 imem_addr SHALL equal the PC register combinationally; PC is 16-bit, word-addressed, +1 per fetch, wrapping 16'hFFFF -> 16'h0000.
REQ-018 PC update priority each edge SHALL be: rst > redirect_en (PC <= redirect_pc) > halted or pc_stall (hold) > PC+1.
REQ-019 IF/ID update priority each edge SHALL be: rst > redirect_en (flush: d_instr <= NOP_INSTR, d_valid <= 0, d_pc_plus1 <= 0) > halted (load bubble) > ifid_stall (hold all IF/ID fields) > load {imem_data, PC+1, valid=1}.
REQ-020 A stall input SHALL count as asserted only when exactly 1'b1; X/Z SHALL be treated as deasserted.
REQ-021 Latency SHALL be one cycle: an instruction at address A appears on d_instr on the edge after imem_addr==A with no stall.
REQ-022 pc_stall=1 with ifid_stall=1 SHALL freeze both PC and IF/ID with no instruction lost or duplicated.
REQ-023 pc_stall=0 with ifid_stall=1 SHALL advance PC while holding IF/ID (fetched word dropped); pc_stall=1 with ifid_stall=0 SHALL reload IF/ID with the same word (duplicate); both are legal and modelled literally.
REQ-024 When an instruction with imem_data[15:12]==HLT_OPCODE is loaded into IF/ID, halted SHALL rise on that same edge; from then PC holds and IF/ID receives bubbles on subsequent edges.
REQ-025 redirect_en while halted SHALL clear halted, load redirect_pc, and flush IF/ID (squashes speculatively fetched HLT).
REQ-026 redirect_en coincident with pc_stall/ifid_stall SHALL take effect; stalls are ignored that cycle.
REQ-027 An HLT word that is flushed by redirect on the same edge SHALL NOT set halted.

Reset
REQ-028 On rst=1 at a rising edge: PC <= RESET_PC, d_instr <= NOP_INSTR, d_pc_plus1 <= 0, d_valid <= 0, halted <= 0, stall_cycles <= 0.
REQ-029 rst asserted mid-stall or mid-halt SHALL override all other inputs; the first fetch after release is from RESET_PC.

Configuration
REQ-030 With macro IF_STALL_CNT_EN defined, stall_cycles SHALL increment by 1 on each non-reset edge where pc_stall==1 and redirect_en==0, saturating at 16'hFFFF.
REQ-031 Without IF_STALL_CNT_EN, stall_cycles SHALL be constant 16'h0000 and no counter flops SHALL exist; all other behaviour is identical.

Verification
REQ-032 Reset then 4 free cycles, imem returns 16'h1000+addr -> d_instr 1000,1001,1002 on edges 2-4, d_pc_plus1 1,2,3, d_valid=1 from edge 2.
REQ-033 PC=5, pc_stall=ifid_stall=1 for 2 cycles -> imem_addr stays 5, d_instr holds word@4 for 2 cycles, then word@5 next edge; with IF_STALL_CNT_EN stall_cycles=2.
REQ-034 PC=8, redirect_en=1, redirect_pc=16'h0040, stalls=1 same cycle -> next edge imem_addr=0x40, d_instr=NOP_INSTR, d_valid=0; following edge d_instr=word@0x40.
REQ-035 Word@3=16'hF000 -> halted=1 on edge loading it, imem_addr frozen at 4, d_valid=0 thereafter; then redirect_pc=0x10 -> halted=0, fetch resumes at 0x10.
REQ-036 PC=16'hFFFF free-running -> next imem_addr=16'h0000, d_pc_plus1=16'h0000; rst during halt -> imem_addr=RESET_PC, halted=0.
REQ-037 pc_stall=1'bx, ifid_stall=1'bz -> treated as 0, PC advances normally, stall_cycles unchanged.
